// File: rtl/dram_reader.sv
// dram_reader: AXI3 read master streaming a contiguous DRAM region into a 64-bit stream.
// Define DRAMREADER_ERR_EN to add a sticky ERR output for RRESP/RLAST faults.
module dram_reader #(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        ACLK,
  input  logic        ARESET,
  output logic [31:0] M_AXI_ARADDR,
  output logic        M_AXI_ARVALID,
  input  logic        M_AXI_ARREADY,
  output logic [3:0]  M_AXI_ARLEN,
  output logic [1:0]  M_AXI_ARSIZE,
  output logic [1:0]  M_AXI_ARBURST,
  input  logic [63:0] M_AXI_RDATA,
  input  logic [1:0]  M_AXI_RRESP,
  input  logic        M_AXI_RLAST,
  input  logic        M_AXI_RVALID,
  output logic        M_AXI_RREADY,
  input  logic        CONFIG_VALID,
  output logic        CONFIG_READY,
  input  logic [31:0] CONFIG_START_ADDR,
  input  logic [31:0] CONFIG_NBYTES,
  output logic [63:0] dout,
  output logic        dout_valid,
`ifdef DRAMREADER_ERR_EN
  output logic        ERR,
`endif
  input  logic        dout_ready
);

  localparam logic [3:0] MAX_O = 4'(MAX_OUTSTANDING);

  typedef enum logic {
    A_IDLE,
    A_ISSUE
  } a_state_t;

  typedef enum logic {
    D_IDLE,
    D_RECV
  } d_state_t;

  a_state_t    r_astate;
  a_state_t    w_anext;
  d_state_t    r_dstate;
  d_state_t    w_dnext;
  logic [31:0] r_araddr;
  logic [24:0] r_acount;
  logic [28:0] r_rcount;
  logic [3:0]  r_outst;
  logic [3:0]  r_beat;
  logic [24:0] w_nbursts;
  logic        w_cfg_acc;
  logic        w_cfg_go;
  logic        w_ar_hs;
  logic        w_r_hs;
  logic        w_rlast_hs;
  logic        w_beat_bad;

  assign w_nbursts  = CONFIG_NBYTES[31:7];
  assign w_cfg_acc  = CONFIG_VALID && CONFIG_READY;
  assign w_cfg_go   = w_cfg_acc && (w_nbursts != '0);
  assign w_ar_hs    = M_AXI_ARVALID && M_AXI_ARREADY;
  assign w_r_hs     = M_AXI_RVALID && M_AXI_RREADY;
  assign w_rlast_hs = w_r_hs && M_AXI_RLAST;
  assign w_beat_bad = M_AXI_RLAST != (r_beat == 4'd15);

  assign CONFIG_READY  = (r_astate == A_IDLE) && (r_dstate == D_IDLE);
  assign M_AXI_ARADDR  = r_araddr;
  assign M_AXI_ARVALID = (r_astate == A_ISSUE) && (r_outst < MAX_O);
  assign M_AXI_ARLEN   = 4'b1111;
  assign M_AXI_ARSIZE  = 2'b11;
  assign M_AXI_ARBURST = 2'b01;

  // Data path is a zero-latency pass-through gated by the RECV state.
  assign M_AXI_RREADY = (r_dstate == D_RECV) && dout_ready;
  assign dout         = M_AXI_RDATA;
  assign dout_valid   = (r_dstate == D_RECV) && M_AXI_RVALID;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_astate <= A_IDLE;
      r_dstate <= D_IDLE;
    end else begin
      r_astate <= w_anext;
      r_dstate <= w_dnext;
    end
  end

  always_comb begin
    w_anext = r_astate;
    unique case (r_astate)
      A_IDLE: begin
        if (w_cfg_go) w_anext = A_ISSUE;
      end
      A_ISSUE: begin
        if (w_ar_hs && (r_acount == 25'd1)) w_anext = A_IDLE;
      end
      default: w_anext = A_IDLE;
    endcase
  end

  always_comb begin
    w_dnext = r_dstate;
    unique case (r_dstate)
      D_IDLE: begin
        if (w_cfg_go) w_dnext = D_RECV;
      end
      D_RECV: begin
        if (w_r_hs && (r_rcount == 29'd1)) w_dnext = D_IDLE;
      end
      default: w_dnext = D_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_araddr <= '0;
      r_acount <= '0;
      r_rcount <= '0;
      r_beat   <= '0;
    end else if (w_cfg_acc) begin
      r_araddr <= CONFIG_START_ADDR;
      r_acount <= w_nbursts;
      r_rcount <= {w_nbursts, 4'b0000};
      r_beat   <= '0;
    end else begin
      if (w_ar_hs) begin
        r_araddr <= r_araddr + 32'd128;
        r_acount <= r_acount - 25'd1;
      end
      if (w_r_hs) begin
        r_rcount <= r_rcount - 29'd1;
        r_beat   <= r_beat + 4'd1;
      end
    end
  end

  // Simultaneous issue and burst completion leave the count unchanged.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_outst <= '0;
    end else begin
      unique case ({w_ar_hs, w_rlast_hs})
        2'b10: r_outst <= r_outst + 4'd1;
        2'b01: begin
          if (r_outst != '0) r_outst <= r_outst - 4'd1;
        end
        default: r_outst <= r_outst;
      endcase
    end
  end

`ifdef DRAMREADER_ERR_EN
  logic r_err;
  logic w_unused;

  assign ERR      = r_err;
  assign w_unused = ^CONFIG_NBYTES[6:0];

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_err <= 1'b0;
    end else if (w_cfg_acc) begin
      r_err <= 1'b0;
    end else if (w_r_hs && ((M_AXI_RRESP != 2'b00) || w_beat_bad)) begin
      r_err <= 1'b1;
    end
  end
`else
  logic w_unused;

  assign w_unused = ^{CONFIG_NBYTES[6:0], M_AXI_RRESP, w_beat_bad};
`endif

endmodule

// File: tb/tb_dram_reader.sv
// tb_dram_reader: randomized bench for dram_reader with an AXI slave model
// and a reference model of the expected AR addresses and stream data.
module tb_dram_reader;

  localparam int MAXO = 4;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [31:0] M_AXI_ARADDR;
  logic        M_AXI_ARVALID;
  logic        M_AXI_ARREADY;
  logic [3:0]  M_AXI_ARLEN;
  logic [1:0]  M_AXI_ARSIZE;
  logic [1:0]  M_AXI_ARBURST;
  logic [63:0] M_AXI_RDATA;
  logic [1:0]  M_AXI_RRESP;
  logic        M_AXI_RLAST;
  logic        M_AXI_RVALID;
  logic        M_AXI_RREADY;
  logic        CONFIG_VALID;
  logic        CONFIG_READY;
  logic [31:0] CONFIG_START_ADDR;
  logic [31:0] CONFIG_NBYTES;
  logic [63:0] dout;
  logic        dout_valid;
  logic        dout_ready;
`ifdef DRAMREADER_ERR_EN
  logic        ERR;
`endif

  dram_reader #(.MAX_OUTSTANDING(MAXO)) dut (
    .ACLK(ACLK),
    .ARESET(ARESET),
    .M_AXI_ARADDR(M_AXI_ARADDR),
    .M_AXI_ARVALID(M_AXI_ARVALID),
    .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_ARLEN(M_AXI_ARLEN),
    .M_AXI_ARSIZE(M_AXI_ARSIZE),
    .M_AXI_ARBURST(M_AXI_ARBURST),
    .M_AXI_RDATA(M_AXI_RDATA),
    .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RLAST(M_AXI_RLAST),
    .M_AXI_RVALID(M_AXI_RVALID),
    .M_AXI_RREADY(M_AXI_RREADY),
    .CONFIG_VALID(CONFIG_VALID),
    .CONFIG_READY(CONFIG_READY),
    .CONFIG_START_ADDR(CONFIG_START_ADDR),
    .CONFIG_NBYTES(CONFIG_NBYTES),
    .dout(dout),
    .dout_valid(dout_valid),
`ifdef DRAMREADER_ERR_EN
    .ERR(ERR),
`endif
    .dout_ready(dout_ready)
  );

  always #5 ACLK = ~ACLK;

  int n_cmp = 0;
  int n_bad = 0;

  int ar_pct = 100;
  int r_pct = 100;
  int dr_mode = 0;
  int r_budget = 1 << 30;
  int inj_beat = -1;
  bit cfg_v = 1'b0;
  logic [31:0] cfg_a = '0;
  logic [31:0] cfg_n = '0;

  logic [31:0] rq[$];
  int bidx = 0;
  bit rv_hold = 1'b0;
  bit tog = 1'b0;

  logic [31:0] ar_log[$];
  logic [63:0] got[$];
  logic [31:0] exp_ar[$];
  logic [63:0] exp_d[$];
  int ar_cnt = 0;
  int cyc = 0;
  int last_beat_cyc = 0;
  int max_rq = 0;
  bit cfg_acc = 1'b0;
  bit arv_seen = 1'b0;
  bit inj_hit = 1'b0;

  function automatic logic [63:0] memd(input logic [31:0] a);
    return {a, a ^ 32'hA5A5_5A5A};
  endfunction

  // Contiguous region split into 128-byte bursts of eight-byte words.
  function automatic void ref_model(input logic [31:0] a, input logic [31:0] n);
    int nb;
    logic [31:0] ba;
    exp_ar.delete();
    exp_d.delete();
    nb = int'(n >> 7);
    for (int b = 0; b < nb; b++) begin
      ba = a + 32'(b * 128);
      exp_ar.push_back(ba);
      for (int k = 0; k < 16; k++) exp_d.push_back(memd(ba + 32'(k * 8)));
    end
  endfunction

  task automatic clr();
    ar_log.delete();
    got.delete();
    ar_cnt = 0;
    arv_seen = 1'b0;
    inj_hit = 1'b0;
    max_rq = 0;
    r_budget = 1 << 30;
    cfg_acc = 1'b0;
  endtask

  // One clock: drive at negedge, settle, then record the handshakes
  // that the coming posedge will commit.
  task automatic cycle();
    @(negedge ACLK);
    CONFIG_VALID = cfg_v;
    CONFIG_START_ADDR = cfg_a;
    CONFIG_NBYTES = cfg_n;
    M_AXI_ARREADY = ($urandom_range(99) < ar_pct);
    if (!rv_hold && rq.size() > 0 && r_budget > 0 && $urandom_range(99) < r_pct)
      rv_hold = 1'b1;
    M_AXI_RVALID = rv_hold;
    if (rv_hold) begin
      M_AXI_RDATA = memd(rq[0] + 32'(8 * bidx));
      M_AXI_RLAST = (bidx == 15);
      M_AXI_RRESP = (inj_beat == bidx) ? 2'b10 : 2'b00;
    end else begin
      M_AXI_RDATA = {$urandom, $urandom};
      M_AXI_RLAST = 1'b0;
      M_AXI_RRESP = 2'b00;
    end
    case (dr_mode)
      0: dout_ready = 1'b1;
      1: begin
        tog = !tog;
        dout_ready = tog;
      end
      default: dout_ready = 1'($urandom_range(1));
    endcase
    #1;
    cfg_acc = CONFIG_VALID && CONFIG_READY;
    if (M_AXI_ARVALID) arv_seen = 1'b1;
    if (M_AXI_ARVALID && M_AXI_ARREADY) begin
      rq.push_back(M_AXI_ARADDR);
      ar_log.push_back(M_AXI_ARADDR);
      ar_cnt++;
      if (rq.size() > max_rq) max_rq = rq.size();
    end
    if (dout_valid && dout_ready) begin
      got.push_back(dout);
      last_beat_cyc = cyc;
    end
    if (M_AXI_RVALID && M_AXI_RREADY) begin
      if (M_AXI_RRESP != 2'b00) begin
        inj_beat = -1;
        inj_hit = 1'b1;
      end
      rv_hold = 1'b0;
      if (bidx == 15) begin
        bidx = 0;
        void'(rq.pop_front());
        r_budget--;
      end else begin
        bidx++;
      end
    end
    cyc++;
  endtask

  task automatic start_cfg(input logic [31:0] a, input logic [31:0] n, output bit acc);
    cfg_a = a;
    cfg_n = n;
    cfg_v = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) begin
      cycle();
      acc = cfg_acc;
    end
    cfg_v = 1'b0;
  endtask

  task automatic drain(input int budget, output bit done);
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      cycle();
      if (CONFIG_READY && got.size() == exp_d.size()) done = 1'b1;
    end
  endtask

  task automatic test_reset();
    ARESET = 1'b1;
    CONFIG_VALID = 1'b0;
    CONFIG_START_ADDR = '0;
    CONFIG_NBYTES = '0;
    M_AXI_ARREADY = 1'b0;
    M_AXI_RVALID = 1'b0;
    M_AXI_RDATA = '0;
    M_AXI_RRESP = '0;
    M_AXI_RLAST = 1'b0;
    dout_ready = 1'b1;
    repeat (3) @(negedge ACLK);
    #1;
    n_cmp++;
    if ({M_AXI_ARVALID, M_AXI_RREADY, dout_valid} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_valids: got %b required 000",
               {M_AXI_ARVALID, M_AXI_RREADY, dout_valid});
    end
    n_cmp++;
    if (M_AXI_ARADDR !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_araddr: got %h required 0", M_AXI_ARADDR);
    end
    n_cmp++;
    if (CONFIG_READY !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_cfg_ready: got %b required 1", CONFIG_READY);
    end
    n_cmp++;
    if ({M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST} !== 8'b1111_11_01) begin
      n_bad++;
      $display("FAIL ar_consts: got %b required 11111101",
               {M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST});
    end
`ifdef DRAMREADER_ERR_EN
    n_cmp++;
    if (ERR !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_err: got %b required 0", ERR);
    end
`endif
    @(negedge ACLK);
    ARESET = 1'b0;
  endtask

  task automatic test_basic();
    bit acc;
    int rdy_cyc;
    clr();
    ar_pct = 100;
    r_pct = 100;
    dr_mode = 0;
    ref_model(32'h1000, 32'd256);
    start_cfg(32'h1000, 32'd256, acc);
    n_cmp++;
    if (!acc) begin
      n_bad++;
      $display("FAIL basic_accept: got %b required 1", acc);
    end
    rdy_cyc = -1;
    for (int i = 0; i < 400 && rdy_cyc < 0; i++) begin
      cycle();
      if (CONFIG_READY && got.size() == 32) rdy_cyc = cyc - 1;
    end
    n_cmp++;
    if (ar_log.size() !== 2) begin
      n_bad++;
      $display("FAIL basic_ar_count: got %0d required 2", ar_log.size());
    end else begin
      n_cmp++;
      if (ar_log[0] !== 32'h1000 || ar_log[1] !== 32'h1080) begin
        n_bad++;
        $display("FAIL basic_ar_addr: got %h,%h required 1000,1080", ar_log[0], ar_log[1]);
      end
    end
    n_cmp++;
    if (got.size() !== exp_d.size()) begin
      n_bad++;
      $display("FAIL basic_beats: got %0d required %0d", got.size(), exp_d.size());
    end
    for (int i = 0; i < got.size() && i < exp_d.size(); i++) begin
      n_cmp++;
      if (got[i] !== exp_d[i]) begin
        n_bad++;
        $display("FAIL basic_data[%0d]: got %h required %h", i, got[i], exp_d[i]);
      end
    end
    n_cmp++;
    if (rdy_cyc !== last_beat_cyc + 1) begin
      n_bad++;
      $display("FAIL basic_ready_timing: got cycle %0d required %0d", rdy_cyc, last_beat_cyc + 1);
    end
  endtask

  task automatic test_outstanding();
    bit acc;
    bit done;
    clr();
    ar_pct = 100;
    r_pct = 100;
    dr_mode = 0;
    r_budget = 0;
    ref_model(32'h0004_0000, 32'd1024);
    start_cfg(32'h0004_0000, 32'd1024, acc);
    repeat (20) cycle();
    n_cmp++;
    if (ar_cnt !== MAXO) begin
      n_bad++;
      $display("FAIL outst_limit: got %0d AR required %0d", ar_cnt, MAXO);
    end
    n_cmp++;
    if (M_AXI_ARVALID !== 1'b0) begin
      n_bad++;
      $display("FAIL outst_arvalid: got %b required 0", M_AXI_ARVALID);
    end
    r_budget = 1;
    repeat (40) cycle();
    n_cmp++;
    if (ar_cnt !== MAXO + 1) begin
      n_bad++;
      $display("FAIL outst_one_more: got %0d AR required %0d", ar_cnt, MAXO + 1);
    end
    r_budget = 1 << 30;
    drain(2000, done);
    n_cmp++;
    if (!done) begin
      n_bad++;
      $display("FAIL outst_done: got %0d beats required %0d", got.size(), exp_d.size());
    end
    n_cmp++;
    if (ar_log.size() !== exp_ar.size()) begin
      n_bad++;
      $display("FAIL outst_ar_total: got %0d required %0d", ar_log.size(), exp_ar.size());
    end
    for (int i = 0; i < got.size() && i < exp_d.size(); i++) begin
      n_cmp++;
      if (got[i] !== exp_d[i]) begin
        n_bad++;
        $display("FAIL outst_data[%0d]: got %h required %h", i, got[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    bit acc;
    bit done;
    clr();
    ar_pct = 100;
    r_pct = 100;
    dr_mode = 1;
    ref_model(32'h0000_8000, 32'd128);
    start_cfg(32'h0000_8000, 32'd128, acc);
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      cycle();
      n_cmp++;
      if (M_AXI_RREADY !== (!CONFIG_READY && dout_ready)) begin
        n_bad++;
        $display("FAIL bp_rready: got %b required %b", M_AXI_RREADY, !CONFIG_READY && dout_ready);
      end
      if (CONFIG_READY && got.size() == exp_d.size()) done = 1'b1;
    end
    n_cmp++;
    if (got.size() !== 16) begin
      n_bad++;
      $display("FAIL bp_beats: got %0d required 16", got.size());
    end
    for (int i = 0; i < got.size() && i < exp_d.size(); i++) begin
      n_cmp++;
      if (got[i] !== exp_d[i]) begin
        n_bad++;
        $display("FAIL bp_data[%0d]: got %h required %h", i, got[i], exp_d[i]);
      end
    end
    dr_mode = 0;
  endtask

  task automatic test_zero_partial();
    bit acc;
    bit done;
    bit rdy_all;
    clr();
    ar_pct = 100;
    r_pct = 100;
    dr_mode = 0;
    start_cfg(32'h3000, 32'd100, acc);
    n_cmp++;
    if (!acc) begin
      n_bad++;
      $display("FAIL zero_accept: got %b required 1", acc);
    end
    rdy_all = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (CONFIG_READY !== 1'b1) rdy_all = 1'b0;
    end
    n_cmp++;
    if (arv_seen || !rdy_all) begin
      n_bad++;
      $display("FAIL zero_idle: got arvalid_seen=%b ready_all=%b required 0,1", arv_seen, rdy_all);
    end
    clr();
    ref_model(32'h3000, 32'd200);
    start_cfg(32'h3000, 32'd200, acc);
    drain(300, done);
    n_cmp++;
    if (!done || ar_cnt !== 1 || got.size() !== 16) begin
      n_bad++;
      $display("FAIL partial_one_burst: got done=%b ar=%0d beats=%0d required 1,1,16",
               done, ar_cnt, got.size());
    end
    for (int i = 0; i < got.size() && i < exp_d.size(); i++) begin
      n_cmp++;
      if (got[i] !== exp_d[i]) begin
        n_bad++;
        $display("FAIL partial_data[%0d]: got %h required %h", i, got[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_random();
    bit acc;
    bit done;
    logic [31:0] a;
    logic [31:0] n;
    for (int it = 0; it < 6; it++) begin
      clr();
      ar_pct = int'($urandom_range(100, 30));
      r_pct = int'($urandom_range(100, 30));
      dr_mode = 2;
      a = (it == 0) ? 32'hFFFF_FF00 : ($urandom & 32'hFFFF_FF80);
      n = (it == 0) ? 32'd512 : 32'($urandom_range(1600));
      ref_model(a, n);
      start_cfg(a, n, acc);
      drain(8000, done);
      n_cmp++;
      if (!done) begin
        n_bad++;
        $display("FAIL rand%0d_done: got %0d beats required %0d", it, got.size(), exp_d.size());
      end
      n_cmp++;
      if (ar_log.size() !== exp_ar.size()) begin
        n_bad++;
        $display("FAIL rand%0d_ar_count: got %0d required %0d", it, ar_log.size(), exp_ar.size());
      end
      for (int i = 0; i < ar_log.size() && i < exp_ar.size(); i++) begin
        n_cmp++;
        if (ar_log[i] !== exp_ar[i]) begin
          n_bad++;
          $display("FAIL rand%0d_ar[%0d]: got %h required %h", it, i, ar_log[i], exp_ar[i]);
        end
      end
      for (int i = 0; i < got.size() && i < exp_d.size(); i++) begin
        n_cmp++;
        if (got[i] !== exp_d[i]) begin
          n_bad++;
          $display("FAIL rand%0d_data[%0d]: got %h required %h", it, i, got[i], exp_d[i]);
        end
      end
      n_cmp++;
      if (max_rq > MAXO) begin
        n_bad++;
        $display("FAIL rand%0d_outstanding: got %0d required <= %0d", it, max_rq, MAXO);
      end
    end
    dr_mode = 0;
    ar_pct = 100;
    r_pct = 100;
  endtask

  task automatic test_reset_mid();
    bit acc;
    bit done;
    clr();
    r_pct = 100;
    ar_pct = 100;
    dr_mode = 0;
    start_cfg(32'h2000, 32'd512, acc);
    for (int i = 0; i < 200 && got.size() < 5; i++) cycle();
    @(negedge ACLK);
    ARESET = 1'b1;
    #1;
    n_cmp++;
    if ({M_AXI_ARVALID, M_AXI_RREADY, dout_valid} !== 3'b000) begin
      n_bad++;
      $display("FAIL rstmid_outputs: got %b required 000",
               {M_AXI_ARVALID, M_AXI_RREADY, dout_valid});
    end
    rq.delete();
    bidx = 0;
    rv_hold = 1'b0;
    M_AXI_RVALID = 1'b0;
    @(negedge ACLK);
    ARESET = 1'b0;
    #1;
    n_cmp++;
    if (CONFIG_READY !== 1'b1) begin
      n_bad++;
      $display("FAIL rstmid_cfg_ready: got %b required 1", CONFIG_READY);
    end
    clr();
    ref_model(32'h9000, 32'd128);
    start_cfg(32'h9000, 32'd128, acc);
    drain(300, done);
    n_cmp++;
    if (!done || ar_log.size() !== 1) begin
      n_bad++;
      $display("FAIL rstmid_recover: got done=%b ar=%0d required 1,1", done, ar_log.size());
    end
    for (int i = 0; i < got.size() && i < exp_d.size(); i++) begin
      n_cmp++;
      if (got[i] !== exp_d[i]) begin
        n_bad++;
        $display("FAIL rstmid_data[%0d]: got %h required %h", i, got[i], exp_d[i]);
      end
    end
  endtask

`ifdef DRAMREADER_ERR_EN
  task automatic test_err();
    bit acc;
    bit done;
    bit seen;
    bit err_ok;
    clr();
    ar_pct = 100;
    r_pct = 100;
    dr_mode = 0;
    ref_model(32'h5000, 32'd256);
    inj_beat = 3;
    start_cfg(32'h5000, 32'd256, acc);
    seen = 1'b0;
    err_ok = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      cycle();
      if (ERR !== seen) err_ok = 1'b0;
      if (inj_hit) seen = 1'b1;
      if (CONFIG_READY && got.size() == exp_d.size()) done = 1'b1;
    end
    n_cmp++;
    if (!err_ok || !seen) begin
      n_bad++;
      $display("FAIL err_sticky: got ok=%b hit=%b required 1,1", err_ok, seen);
    end
    n_cmp++;
    if (ERR !== 1'b1) begin
      n_bad++;
      $display("FAIL err_end: got %b required 1", ERR);
    end
    start_cfg(32'h6000, 32'd0, acc);
    cycle();
    n_cmp++;
    if (ERR !== 1'b0) begin
      n_bad++;
      $display("FAIL err_clear: got %b required 0", ERR);
    end
    inj_beat = -1;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_outstanding();
    test_backpressure();
    test_zero_partial();
    test_random();
    test_reset_mid();
`ifdef DRAMREADER_ERR_EN
    test_err();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dram_reader.md
Name: dram_reader

Overview:
- AXI3 read master that streams a contiguous DRAM region into a 64-bit valid/ready output stream.
- It is the read-direction counterpart of the team's DRAM writer and uses the same burst geometry: 16 beats x 8 bytes = 128 bytes per burst, INCR.
- It is configured by a start address and byte count over a valid/ready config handshake, and feeds downstream pipeline stages.

Parameters:
- MAX_OUTSTANDING, 4, maximum number of AR bursts issued but not yet fully returned (legal range 1..15).

Ports:
- ACLK  in  1  clock.
- ARESET  in  1  reset; one clock, reset is asynchronous and active-high.
- M_AXI_ARADDR  out  32  burst address.
- M_AXI_ARVALID  out  1  address valid.
- M_AXI_ARREADY  in  1  address accepted.
- M_AXI_ARLEN  out  4  tied to 4'b1111.
- M_AXI_ARSIZE  out  2  tied to 2'b11.
- M_AXI_ARBURST  out  2  tied to 2'b01.
- M_AXI_RDATA  in  64  read data.
- M_AXI_RRESP  in  2  read response.
- M_AXI_RLAST  in  1  last beat of burst.
- M_AXI_RVALID  in  1  read data valid.
- M_AXI_RREADY  out  1  read data ready.
- CONFIG_VALID  in  1  config request.
- CONFIG_READY  out  1  block idle, config accepted.
- CONFIG_START_ADDR  in  32  start byte address (128-byte aligned).
- CONFIG_NBYTES  in  32  byte count; bits [6:0] ignored.
- dout  out  64  stream data.
- dout_valid  out  1  stream valid.
- dout_ready  in  1  stream ready.

Behaviour:
- Reset values: ARADDR=0, ARVALID=0, RREADY=0, dout_valid=0, CONFIG_READY=1. Internal counters reset to 0; both FSMs reset to IDLE.
- Config handshake:
  - Accepted when CONFIG_VALID && CONFIG_READY.
  - CONFIG_READY = (a_state==IDLE) && (r_state==IDLE).
  - On acceptance: ARADDR<=START_ADDR; a_count<=NBYTES[31:7]; r_count<=NBYTES[31:7]*16 beats.
  - If NBYTES[31:7]==0, the config is accepted but both FSMs stay IDLE; no AXI traffic is generated.
- Address FSM, states IDLE / ISSUE:
  - IDLE->ISSUE on an accepted config with a nonzero burst count.
  - ARVALID = (a_state==ISSUE) && (outstanding < MAX_OUTSTANDING).
  - On ARVALID&&ARREADY: ARADDR += 128; a_count -= 1; when a_count==1 go IDLE.
  - ARADDR stays stable while ARVALID is high and ARREADY is low.
- Outstanding counter:
  - +1 on each AR handshake; -1 on each R handshake with RLAST.
  - Both in the same cycle: no change.
  - Never exceeds MAX_OUTSTANDING.
- Data FSM, states IDLE / RECV:
  - M_AXI_RREADY = (r_state==RECV) && dout_ready.
  - dout = RDATA and dout_valid = (r_state==RECV) && RVALID, both combinational (zero latency).
  - Each handshake decrements r_count; at r_count==1 go IDLE.
- Beat tracking: a 4-bit beat counter starts at 0 and increments per beat; it checks that RLAST coincides with beat 15. A mismatch does not alter flow.
- Address wrap: 32-bit ARADDR wraps modulo 2^32 silently.
- Back-pressure: dout_ready low stalls RREADY; AR issue continues until MAX_OUTSTANDING is reached.
- CONFIG_VALID while busy: ignored; CONFIG_READY is 0.
- Reset mid-operation: all state clears immediately. In-flight AXI responses arriving after reset are dropped (RREADY=0 in IDLE). The system must reset the interconnect together with this block.

Optional Feature:
- Macro: DRAMREADER_ERR_EN.
- Defined: adds output port ERR (1 bit, reset 0). ERR sets sticky on any R handshake with RRESP!=2'b00 or an RLAST/beat-15 mismatch. It clears on the next accepted config.
- Undefined: no ERR port; RRESP and RLAST are ignored apart from outstanding accounting.

Test Plan:
- Basic read: START_ADDR=0x1000, NBYTES=256, ARREADY=1, RVALID always, dout_ready=1 -> exactly 2 AR beats (0x1000, 0x1080); 32 dout beats with data order preserved; CONFIG_READY returns to 1 the cycle after the 32nd beat.
- Outstanding limit: NBYTES=1024, MAX_OUTSTANDING=4, R channel silent -> exactly 4 AR handshakes then ARVALID=0. Return one burst -> exactly one more AR issued.
- Back-pressure: dout_ready toggled 1/0 every cycle on a 128-byte read -> RREADY mirrors dout_ready; 16 beats delivered; no duplicates or drops.
- Zero/partial size: NBYTES=100 -> config accepted, no ARVALID ever, CONFIG_READY stays 1. NBYTES=200 -> one burst only.
- Reset mid-burst: assert ARESET after 5 of 16 beats -> ARVALID, RREADY and dout_valid are 0 immediately; CONFIG_READY=1 after release.
- Error flag (DRAMREADER_ERR_EN): RRESP=2'b10 on beat 3 -> ERR=1 from the next cycle, remains 1 through end of transfer, clears on next config.
